// File: rtl/crypt_round_engine_if.sv
// Plaintext/ciphertext handshake bundle for crypt_round_engine.
// The master drives pt/in_valid/out_ready; the engine is the slave.
interface crypt_round_engine_if;
    logic [7:0] pt;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ct;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output pt, in_valid, out_ready,
        input  in_ready, ct, out_valid
    );

    modport slave (
        input  pt, in_valid, out_ready,
        output in_ready, ct, out_valid
    );
endinterface

// File: rtl/crypt_round_engine.sv
// Three-round 8-bit iterative cipher engine with valid/ready handshake.
// Define CRYPT_DECRYPT_EN to add the mode port and the inverse (decrypt) round.
module crypt_round_engine (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       en,
    input  logic [7:0]                 K_1,
    input  logic [7:0]                 K_2,
    input  logic [7:0]                 K_3,
`ifdef CRYPT_DECRYPT_EN
    input  logic                       mode,
`endif
    crypt_round_engine_if.slave        bus,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] rc_q, rc_d;
    logic [7:0] s_q, s_d;
    logic [7:0] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic       dec_q, dec_d;
    logic [7:0] rk;
    logic [7:0] t;

    function automatic logic [7:0] enc_round(input logic [7:0] s, input logic [7:0] k);
        logic [7:0] x;
        x = (s ^ k) + 8'h5A;
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [7:0] dec_round(input logic [7:0] s, input logic [7:0] k);
        logic [7:0] x;
        x = {s[0], s[7:1]} - 8'h5A;
        return x ^ k;
    endfunction

    assign bus.in_ready  = (state_q == IDLE) && en && RST_N;
    assign bus.out_valid = (state_q == DONE) && en && RST_N;
    assign bus.ct        = s_q;
    assign busy          = (state_q != IDLE);

    // Decrypt walks the key schedule backwards so rc still counts 1..3.
    always_comb begin
        rk = k1_q;
        unique case ({dec_q, rc_q})
            3'b001:  rk = k1_q;
            3'b010:  rk = k2_q;
            3'b011:  rk = k3_q;
            3'b101:  rk = k3_q;
            3'b110:  rk = k2_q;
            3'b111:  rk = k1_q;
            default: rk = k1_q;
        endcase
        t = dec_q ? dec_round(s_q, rk) : enc_round(s_q, rk);
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        s_d     = s_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        dec_d   = dec_q;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_d     = bus.pt;
                        k1_d    = K_1;
                        k2_d    = K_2;
                        k3_d    = K_3;
`ifdef CRYPT_DECRYPT_EN
                        dec_d   = mode;
`else
                        dec_d   = 1'b0;
`endif
                        rc_d    = 2'd1;
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    s_d  = t;
                    rc_d = rc_q + 2'd1;
                    if (rc_q == 2'd3) state_d = DONE;
                end
                DONE: begin
                    if (bus.out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            rc_q    <= '0;
            s_q     <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            s_q     <= s_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            dec_q   <= dec_d;
        end
    end

endmodule
